// File: rtl/dial_switch_pkg.sv
// Shared constants and state encoding for the dial switch reader and related pin readers.
package dial_switch_pkg;
  localparam int SW_WIDTH = 8;
  localparam logic [SW_WIDTH-1:0] SW_RESET_RAW = '1;

  typedef enum logic {S_STABLE, S_SETTLE} dbc_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous pin inputs.
module sync_2ff #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/dial_switch_reader.sv
// Dial switch bank reader: sync, whole-vector debounce, and coalescing change events.
// Optional LED mirror output enabled by defining DIAL_SWITCH_READER_LED_MIRROR_EN.
module dial_switch_reader
  import dial_switch_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [WIDTH-1:0] SWICH,
  output logic [WIDTH-1:0] SW_STATE,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [WIDTH-1:0] EVT_MASK,
  output logic [WIDTH-1:0] EVT_STATE
`ifdef DIAL_SWITCH_READER_LED_MIRROR_EN
  ,
  output logic [WIDTH-1:0] LED
`endif
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  dbc_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] cand, cand_n;
  logic [WIDTH-1:0] sync_raw, sync_on, diff;
  logic             commit, fire, xfer;

  // Pins idle high (switch OFF), so the synchronizer resets to all-ones.
  sync_2ff #(.WIDTH(WIDTH), .RST_VAL({WIDTH{1'b1}})) u_sync (
    .clk   (CLK),
    .rst_n (RST_n),
    .d     (SWICH),
    .q     (sync_raw)
  );

  assign sync_on = ~sync_raw;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    commit  = 1'b0;
    case (state)
      S_STABLE: begin
        if (sync_on != SW_STATE) begin
          cand_n  = sync_on;
          cnt_n   = '0;
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (sync_on != cand) begin
          cand_n = sync_on;
          cnt_n  = '0;
        end else if (cnt == CNT_LAST) begin
          commit  = 1'b1;
          state_n = S_STABLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_STABLE;
    endcase
  end

  // A commit back to the original value is a filtered glitch and stays silent.
  assign fire = commit && (cand != SW_STATE);
  assign diff = SW_STATE ^ cand;
  assign xfer = EVT_VALID && EVT_READY;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_STABLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      SW_STATE  <= '0;
      EVT_VALID <= 1'b0;
      EVT_MASK  <= '0;
      EVT_STATE <= '0;
    end else if (fire) begin
      SW_STATE  <= cand;
      EVT_VALID <= 1'b1;
      EVT_STATE <= cand;
      // Pending and not taken: merge so no toggled bit is ever lost.
      EVT_MASK  <= (EVT_VALID && !EVT_READY) ? (EVT_MASK | diff) : diff;
    end else if (xfer) begin
      EVT_VALID <= 1'b0;
    end
  end

`ifdef DIAL_SWITCH_READER_LED_MIRROR_EN
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) LED <= '1;
    else        LED <= ~SW_STATE;
  end
`endif
endmodule

// File: tb/tb_dial_switch_reader.sv
// Self-checking bench for dial_switch_reader: directed scenarios plus random stimulus vs a run-length model.
module tb_dial_switch_reader;
  localparam int DEB = 16;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [7:0] SWICH = 8'hFF;
  logic       EVT_READY = 1'b0;
  logic [7:0] SW_STATE, EVT_MASK, EVT_STATE;
  logic       EVT_VALID;
`ifdef DIAL_SWITCH_READER_LED_MIRROR_EN
  logic [7:0] LED;
`endif

  int checks = 0;
  int errors = 0;

  dial_switch_reader #(.WIDTH(8), .DEBOUNCE_CYCLES(DEB), .CNT_W(18)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .SWICH     (SWICH),
    .SW_STATE  (SW_STATE),
    .EVT_VALID (EVT_VALID),
    .EVT_READY (EVT_READY),
    .EVT_MASK  (EVT_MASK),
    .EVT_STATE (EVT_STATE)
`ifdef DIAL_SWITCH_READER_LED_MIRROR_EN
    ,
    .LED       (LED)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference: a value commits once the synchronized sample has held for DEB+1
  // consecutive clocks and differs from the current state.
  logic [7:0] m_p1, m_p2, m_last, m_sw, m_mask, m_state, m_s, m_diff;
  logic       m_valid, m_fire;
  int         m_run, m_run_nx;

  always_comb begin
    m_s      = ~m_p2;
    m_run_nx = (m_s == m_last) ? m_run + 1 : 1;
    m_diff   = m_s ^ m_sw;
    m_fire   = (m_run_nx == DEB + 1) && (m_s != m_sw);
  end

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      m_p1 <= 8'hFF; m_p2 <= 8'hFF; m_last <= 8'h00; m_run <= 0;
      m_sw <= 8'h00; m_valid <= 1'b0; m_mask <= 8'h00; m_state <= 8'h00;
    end else begin
      m_p1   <= SWICH;
      m_p2   <= m_p1;
      m_last <= m_s;
      m_run  <= m_run_nx;
      if (m_fire) begin
        m_sw    <= m_s;
        m_state <= m_s;
        m_valid <= 1'b1;
        m_mask  <= (m_valid && !EVT_READY) ? (m_mask | m_diff) : m_diff;
      end else if (m_valid && EVT_READY) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic test_reset;
    int bad;
    RST_n = 1'b0; SWICH = 8'hFF; EVT_READY = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({SW_STATE, EVT_VALID, EVT_MASK, EVT_STATE} !== 25'd0) begin
      errors++;
      $display("FAIL reset_values: got sw=%h v=%b mask=%h st=%h, want all zero", SW_STATE, EVT_VALID, EVT_MASK, EVT_STATE);
    end
    RST_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge CLK);
      if (SW_STATE !== 8'h00 || EVT_VALID !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d cycles with sw/valid nonzero, want 0", bad);
    end
  endtask

  task automatic test_single_change;
    int lat;
    EVT_READY = 1'b1;
    @(negedge CLK);
    SWICH = 8'hFE;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (SW_STATE === 8'h01) begin lat = i; break; end
    end
    checks++;
    if (lat != 19) begin
      errors++;
      $display("FAIL single_latency: got %0d clocks, want 19", lat);
    end
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_MASK !== 8'h01 || EVT_STATE !== 8'h01) begin
      errors++;
      $display("FAIL single_event: got v=%b mask=%h st=%h, want 1/01/01", EVT_VALID, EVT_MASK, EVT_STATE);
    end
    @(negedge CLK);
    checks++;
    if (EVT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle: got valid=%b, want 0", EVT_VALID);
    end
  endtask

  task automatic test_bounce;
    int bad, lat;
    EVT_READY = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      SWICH[3] = ~SWICH[3];
      repeat (5) begin
        @(negedge CLK);
        if (SW_STATE !== 8'h01 || EVT_VALID !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bounce_no_commit: %0d cycles changed during bounce, want 0", bad);
    end
    SWICH[3] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (SW_STATE === 8'h09) begin lat = i; break; end
    end
    checks++;
    if (lat != 19) begin
      errors++;
      $display("FAIL bounce_latency: got %0d clocks, want 19", lat);
    end
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_MASK !== 8'h08 || EVT_STATE !== 8'h09) begin
      errors++;
      $display("FAIL bounce_event: got v=%b mask=%h st=%h, want 1/08/09", EVT_VALID, EVT_MASK, EVT_STATE);
    end
  endtask

  task automatic test_coalesce;
    EVT_READY = 1'b1;
    SWICH = 8'hFF;
    repeat (30) @(negedge CLK);
    checks++;
    if (SW_STATE !== 8'h00 || EVT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL coalesce_setup: got sw=%h v=%b, want 00/0", SW_STATE, EVT_VALID);
    end
    EVT_READY = 1'b0;
    SWICH = 8'hFE;
    repeat (25) @(negedge CLK);
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_MASK !== 8'h01 || EVT_STATE !== 8'h01) begin
      errors++;
      $display("FAIL coalesce_first: got v=%b mask=%h st=%h, want 1/01/01", EVT_VALID, EVT_MASK, EVT_STATE);
    end
    SWICH = 8'hFC;
    repeat (25) @(negedge CLK);
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_MASK !== 8'h03 || EVT_STATE !== 8'h03 || SW_STATE !== 8'h03) begin
      errors++;
      $display("FAIL coalesce_merged: got v=%b mask=%h st=%h sw=%h, want 1/03/03/03", EVT_VALID, EVT_MASK, EVT_STATE, SW_STATE);
    end
    EVT_READY = 1'b1;
    @(negedge CLK);
    checks++;
    if (EVT_VALID !== 1'b0 || EVT_MASK !== 8'h03) begin
      errors++;
      $display("FAIL coalesce_transfer: got v=%b mask=%h, want 0/03", EVT_VALID, EVT_MASK);
    end
  endtask

  task automatic test_glitch;
    int bad;
    EVT_READY = 1'b1;
    bad = 0;
    SWICH[5] = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (SW_STATE !== 8'h03 || EVT_VALID !== 1'b0) bad++;
    end
    SWICH[5] = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      if (SW_STATE !== 8'h03 || EVT_VALID !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_filtered: %0d cycles with change or event, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_settle;
    int bad;
    SWICH[7] = 1'b0;
    repeat (13) @(negedge CLK);
    RST_n = 1'b0;
    #1;
    checks++;
    if ({SW_STATE, EVT_VALID, EVT_MASK, EVT_STATE} !== 25'd0) begin
      errors++;
      $display("FAIL async_reset: got sw=%h v=%b mask=%h st=%h, want all zero", SW_STATE, EVT_VALID, EVT_MASK, EVT_STATE);
    end
    SWICH = 8'hFF;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge CLK);
      if (SW_STATE !== 8'h00 || EVT_VALID !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_event: %0d cycles with change or event, want 0", bad);
    end
  endtask

  task automatic test_random;
    int b, shown, fires;
    shown = 0;
    fires = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      checks++;
      if ({SW_STATE, EVT_VALID, EVT_MASK, EVT_STATE} !== {m_sw, m_valid, m_mask, m_state}) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle_%0d: got sw=%h v=%b mask=%h st=%h, want sw=%h v=%b mask=%h st=%h",
                   i, SW_STATE, EVT_VALID, EVT_MASK, EVT_STATE, m_sw, m_valid, m_mask, m_state);
        end
      end
      if (m_valid && EVT_VALID) fires++;
      if (i == 1000) begin
        RST_n = 1'b0;
        SWICH = 8'h5A;
      end else if (i == 1002) begin
        RST_n = 1'b1;
      end else if (i > 1002 && i < 1030) begin
        SWICH = 8'h5A;
      end else if ($urandom_range(0, 19) == 0) begin
        b = $urandom_range(0, 7);
        SWICH[b] = ~SWICH[b];
      end
      EVT_READY = ($urandom_range(0, 2) != 0);
    end
    checks++;
    if (fires == 0) begin
      errors++;
      $display("FAIL random_activity: got %0d event cycles, want >0", fires);
    end
  endtask

  initial begin
    test_reset();
    test_single_change();
    test_bounce();
    test_coalesce();
    test_glitch();
    test_reset_mid_settle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
